led_rnd_gen: RTL and testbench

LED_RND_GEN -- requirements
Module: led_rnd_gen

---
 rtl/led_rnd_gen.sv | 98 +++++++++
 tb/tb_led_rnd_gen.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_rnd_gen.sv
// 13-bit Fibonacci LFSR random source for RGB LEDs with prescaled free-run, single-step and seed load.
// Optional period counter / period_wrap pulse compiled in with `define LED_RND_PERIOD_CHK_EN.
module led_rnd_gen #(
    parameter int unsigned PRESCALE     = 1,
    parameter logic [12:0] DEFAULT_SEED = 13'h1ACE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        step,
    input  logic        seed_load,
    input  logic [12:0] seed,
    output logic [12:0] rnd,
    output logic        rnd_valid,
    output logic        period_wrap
);

    localparam logic [23:0] PRESCALE_MAX = 24'(PRESCALE - 1);

    logic [23:0] pcnt_q, pcnt_d;
    logic [12:0] rnd_q, rnd_d;
    logic        valid_q, valid_d;
    logic        tick;
    logic        advance;
    logic        fb;

    always_comb begin
        tick    = en & ~seed_load & (pcnt_q == PRESCALE_MAX);
        advance = (tick | step) & ~seed_load;
        fb      = rnd_q[12] ^ rnd_q[3] ^ rnd_q[2] ^ rnd_q[0];

        // Prescaler restarts whenever free-run is interrupted or a seed is loaded.
        pcnt_d = '0;
        if (en && !seed_load && !tick) begin
            pcnt_d = pcnt_q + 24'd1;
        end

        rnd_d   = rnd_q;
        valid_d = 1'b0;
        if (seed_load) begin
            rnd_d   = (seed == '0) ? DEFAULT_SEED : seed;
            valid_d = 1'b1;
        end else if (advance) begin
            rnd_d   = {rnd_q[11:0], fb};
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_q  <= '0;
            rnd_q   <= DEFAULT_SEED;
            valid_q <= 1'b0;
        end else begin
            pcnt_q  <= pcnt_d;
            rnd_q   <= rnd_d;
            valid_q <= valid_d;
        end
    end

    assign rnd       = rnd_q;
    assign rnd_valid = valid_q;

`ifdef LED_RND_PERIOD_CHK_EN
    logic [12:0] per_q, per_d;
    logic        wrap_q, wrap_d;

    always_comb begin
        per_d  = per_q;
        wrap_d = 1'b0;
        if (seed_load) begin
            per_d = '0;
        end else if (advance) begin
            if (per_q == 13'd8190) begin
                per_d  = '0;
                wrap_d = 1'b1;
            end else begin
                per_d = per_q + 13'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            per_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            per_q  <= per_d;
            wrap_q <= wrap_d;
        end
    end

    assign period_wrap = wrap_q;
`else
    assign period_wrap = 1'b0;
`endif

endmodule

// File: tb/tb_led_rnd_gen.sv
// Scoreboard bench for led_rnd_gen: a behavioural model queues each expected new rnd value,
// and a monitor pops and compares on every rnd_valid pulse.
module tb_led_rnd_gen;

    localparam int unsigned PRESCALE = 4;
    localparam logic [12:0] DEF_SEED = 13'h1ACE;
`ifdef LED_RND_PERIOD_CHK_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        en;
    logic        step;
    logic        seed_load;
    logic [12:0] seed;
    logic [12:0] rnd;
    logic        rnd_valid;
    logic        period_wrap;

    led_rnd_gen #(.PRESCALE(PRESCALE), .DEFAULT_SEED(DEF_SEED)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .step       (step),
        .seed_load  (seed_load),
        .seed       (seed),
        .rnd        (rnd),
        .rnd_valid  (rnd_valid),
        .period_wrap(period_wrap)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [12:0] val;
        logic        wrap;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          pulses = 0;
    int          wraps = 0;
    logic [12:0] last_rnd;

    // Reference model state
    logic [12:0] m_rnd;
    int          run_len;
    int          adv_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [12:0] lfsr_next(input logic [12:0] v);
        logic fb;
        fb = v[12] ^ v[3] ^ v[2] ^ v[0];
        return {v[11:0], fb};
    endfunction

    // Predicts the effect of the inputs just driven on the coming clock edge.
    task automatic model_step();
        bit   tick;
        exp_t e;
        if (rst) begin
            m_rnd   = DEF_SEED;
            run_len = 0;
            adv_cnt = 0;
        end else begin
            tick = 1'b0;
            if (en && !seed_load) begin
                run_len++;
                tick = (run_len % PRESCALE) == 0;
            end else begin
                run_len = 0;
            end
            if (seed_load) begin
                m_rnd   = (seed == 13'd0) ? DEF_SEED : seed;
                adv_cnt = 0;
                e.val = m_rnd; e.wrap = 1'b0;
                exp_q.push_back(e);
            end else if (tick || step) begin
                m_rnd = lfsr_next(m_rnd);
                adv_cnt++;
                e.val = m_rnd; e.wrap = WRAP_EN && (adv_cnt % 8191 == 0);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic cycle(input logic r, input logic e, input logic s, input logic l, input logic [12:0] sd);
        @(negedge clk);
        rst = r; en = e; step = s; seed_load = l; seed = sd;
        model_step();
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                check("reset_rnd", 32'(rnd), 32'(DEF_SEED));
                check("reset_valid", 32'(rnd_valid), 32'd0);
                check("reset_wrap", 32'(period_wrap), 32'd0);
                last_rnd = rnd;
            end else if (rnd_valid) begin
                pulses++;
                if (period_wrap) wraps++;
                if (exp_q.size() == 0) begin
                    check("spurious_valid", 32'(rnd_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rnd_value", 32'(rnd), 32'(e.val));
                    check("period_wrap", 32'(period_wrap), 32'(e.wrap));
                end
                last_rnd = rnd;
            end else begin
                check("rnd_hold", 32'(rnd), 32'(last_rnd));
                check("wrap_idle", 32'(period_wrap), 32'd0);
            end
            check("rnd_nonzero", 32'(rnd != 13'd0), 32'd1);
        end
    end

    initial begin
        int p0;
        int w0;
        rst = 1'b1; en = 1'b0; step = 1'b0; seed_load = 1'b0; seed = '0;
        model_step();
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        settle();
        check("post_reset_rnd", 32'(rnd), 32'h1ACE);

        // Single step from reset value
        cycle(0, 0, 1, 0, 0);
        settle();
        check("first_step", 32'(rnd), 32'h159D);
        check("first_step_valid", 32'(rnd_valid), 32'd1);
        cycle(0, 0, 0, 0, 0);
        settle();
        check("valid_one_cycle", 32'(rnd_valid), 32'd0);

        // Seed load, zero-seed substitution
        cycle(0, 0, 0, 1, 13'h0001);
        cycle(0, 0, 1, 0, 0);
        settle();
        check("seed1_step", 32'(rnd), 32'h0003);
        cycle(0, 0, 0, 1, 13'h0000);
        settle();
        check("zero_seed", 32'(rnd), 32'h1ACE);

        // Free-run at PRESCALE=4: 12 enabled cycles give 3 advances
        p0 = pulses;
        for (int i = 0; i < 12; i++) cycle(0, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        settle();
        check("freerun_pulses", 32'(pulses - p0), 32'd3);
        p0 = pulses;
        for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0, 0);
        settle();
        check("frozen_pulses", 32'(pulses - p0), 32'd0);

        // Step coincident with tick, then seed_load coincident with step
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 0);
        p0 = pulses;
        cycle(0, 1, 1, 0, 0);
        cycle(0, 0, 0, 0, 0);
        settle();
        check("tick_step_once", 32'(pulses - p0), 32'd1);
        cycle(0, 1, 1, 1, 13'h0ABC);
        settle();
        check("load_over_step", 32'(rnd), 32'h0ABC);

        // Randomised traffic
        for (int i = 0; i < 2000; i++) begin
            logic r, e, s, l;
            logic [12:0] sd;
            r  = ($urandom_range(199) == 0);
            e  = ($urandom_range(7) == 0) ? ~en : en;
            s  = ($urandom_range(3) == 0);
            l  = ($urandom_range(29) == 0);
            sd = ($urandom_range(4) == 0) ? 13'd0 : 13'($urandom);
            cycle(r, e, s, l, sd);
        end

        // Reset during free-run with a pending step discards it; prescaler restarts
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0, 0);
        cycle(1, 1, 1, 0, 0);
        settle();
        check("rst_mid_rnd", 32'(rnd), 32'h1ACE);
        check("rst_mid_valid", 32'(rnd_valid), 32'd0);
        p0 = pulses;
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 0);
        settle();
        check("rst_prescale_partial", 32'(pulses - p0), 32'd0);
        cycle(0, 1, 0, 0, 0);
        settle();
        check("rst_prescale_full", 32'(pulses - p0), 32'd1);

        // Full period from reset
        cycle(1, 0, 0, 0, 0);
        w0 = wraps;
        for (int i = 0; i < 8191; i++) cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0);
        settle();
        check("period_return", 32'(rnd), 32'h1ACE);
        check("period_wraps", 32'(wraps - w0), WRAP_EN ? 32'd1 : 32'd0);

        cycle(0, 0, 0, 0, 0);
        settle();
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
